// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Instruction-side initiator on a req/gnt/rvalid memory bus. Keeps a
//   program counter, issues one word-aligned fetch at a time and buffers the
//   returned words, tagged with their address, in a small prefetch FIFO that
//   the decode stage drains over a valid/ready handshake. A branch redirects
//   the PC, flushes the FIFO and discards any response still in flight.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   enable_i            fetch permitted; an in-flight transfer always completes
//   instr_req_o         registered request to memory
//   instr_addr_o        registered, word-aligned request byte address
//   instr_gnt_i         request accepted (only looked at while requesting)
//   instr_rvalid_i      response valid (only looked at while awaiting one)
//   instr_rdata_i       response data
//   branch_i            one-cycle redirect strobe
//   branch_addr_i       redirect target (low bits ignored)
//   fetch_valid_o       FIFO head valid
//   fetch_rdata_o       FIFO head instruction
//   fetch_addr_o        FIFO head instruction address
//   fetch_ready_i       consumer pops the head when valid & ready
module instr_fetch_unit #(
  parameter int                     ADDR_WIDTH = 8,
  parameter int                     DATA_WIDTH = 32,
  parameter int                     FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0]  BOOT_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  output logic                  fetch_valid_o,
  output logic [DATA_WIDTH-1:0] fetch_rdata_o,
  output logic [ADDR_WIDTH-1:0] fetch_addr_o,
  input  logic                  fetch_ready_i
);

  localparam int STEP  = DATA_WIDTH / 8;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [ADDR_WIDTH-1:0] STEP_A     = ADDR_WIDTH'(STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(STEP_A - ADDR_WIDTH'(1));
  localparam logic [CNT_W-1:0]      DEPTH_C    = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RV
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic                    req_reg;
  logic [ADDR_WIDTH-1:0]   tag_reg;
  logic                    discard_reg, discard_next;
  logic [CNT_W-1:0]        count_reg, count_next;
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic                    push, pop, credit_ok;
  logic [ADDR_WIDTH-1:0]   branch_target;

  // Packed so that each generated entry owns its own slice.
  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] fifo_addr_reg;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] fifo_data_reg;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign branch_target = branch_addr_i & ALIGN_MASK;

  // FIFO bookkeeping. A branch wins over both a push and a pop in the
  // same cycle, so the FIFO is guaranteed empty after the redirect.
  always_comb begin
    push       = (state_reg == WAIT_RV) && instr_rvalid_i && !discard_reg && !branch_i;
    pop        = (count_reg != '0) && fetch_ready_i && !branch_i;
    count_next = count_reg;
    if (branch_i) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
    // Occupancy after this cycle's push/pop; a new request is only raised
    // while there is room for its response, so a push never overflows.
    credit_ok = (count_next < DEPTH_C);
  end

  // Fetch FSM, PC and discard tracking.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    addr_next    = addr_reg;
    discard_next = discard_reg;

    case (state_reg)
      IDLE:    if (enable_i && credit_ok) state_next = REQ;
      REQ:     if (instr_gnt_i) state_next = WAIT_RV;
      WAIT_RV: if (instr_rvalid_i) state_next = (enable_i && credit_ok) ? REQ : IDLE;
      default: state_next = IDLE;
    endcase

    // A request that was redirected while waiting for gnt leaves the PC at
    // the branch target, so its grant must not advance the PC.
    if (branch_i) begin
      pc_next = branch_target;
    end else if (state_reg == REQ && instr_gnt_i && !discard_reg) begin
      pc_next = addr_reg + STEP_A;
    end

    // discard marks the single outstanding transaction as stale. It is
    // cleared when that response is consumed (a branch in the same cycle
    // drops the response through the push gating instead).
    if (state_reg == WAIT_RV && instr_rvalid_i) begin
      discard_next = 1'b0;
    end else if (branch_i && state_reg != IDLE) begin
      discard_next = 1'b1;
    end

    // The request address is captured on entry to REQ and then held
    // stable until the grant, even across a redirect.
    if (state_reg != REQ && state_next == REQ) begin
      addr_next = branch_i ? branch_target : pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      pc_reg      <= BOOT_ADDR;
      addr_reg    <= BOOT_ADDR;
      req_reg     <= 1'b0;
      tag_reg     <= '0;
      discard_reg <= 1'b0;
      count_reg   <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      addr_reg    <= addr_next;
      req_reg     <= (state_next == REQ);
      discard_reg <= discard_next;
      count_reg   <= count_next;
      if (state_reg == REQ && instr_gnt_i) begin
        tag_reg <= addr_reg;
      end
      if (branch_i) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
        if (pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      end
    end
  end

  // Prefetch storage, one register pair per entry; cleared on reset so the
  // head fields read as zero until the first push.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        fifo_addr_reg[gi] <= '0;
        fifo_data_reg[gi] <= '0;
      end else if (push && wr_ptr_reg == PTR_W'(gi)) begin
        fifo_addr_reg[gi] <= tag_reg;
        fifo_data_reg[gi] <= instr_rdata_i;
      end
    end
  end

  assign instr_req_o   = req_reg;
  assign instr_addr_o  = addr_reg;
  assign fetch_valid_o = (count_reg != '0);
  assign fetch_addr_o  = fifo_addr_reg[rd_ptr_reg];
  assign fetch_rdata_o = fifo_data_reg[rd_ptr_reg];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Scoreboard bench for instr_fetch_unit with default parameters
//   (8-bit addresses, 32-bit words, two-entry FIFO, boot address 0).
//   A mock memory answers the fetch bus; expected (addr, data) words are
//   queued by the stimulus and checked by an independent monitor as the
//   consumer pops them.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        enable_i;
  logic        instr_req_o;
  logic [7:0]  instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        branch_i;
  logic [7:0]  branch_addr_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_rdata_o;
  logic [7:0]  fetch_addr_o;
  logic        fetch_ready_i;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_rdata_o  (fetch_rdata_o),
    .fetch_addr_o   (fetch_addr_o),
    .fetch_ready_i  (fetch_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] gnt_log[$];
  int         errors = 0;
  int         checks = 0;

  // Mock memory state
  int         rv_lat = 0;
  logic       mem_pending = 1'b0;
  logic [7:0] mem_addr = '0;
  int         mem_wait = 0;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    case (a)
      8'h00:   return 32'h00D00113;
      8'h04:   return 32'h00900093;
      8'h08:   return 32'h401101B3;
      8'h0C:   return 32'h0BADF00D;
      8'h80:   return 32'hF81FF06F;
      8'h84:   return 32'h1A1A1A1A;
      default: return {24'h111100, a};
    endcase
  endfunction

  // Memory: grants a visible request immediately, returns data rv_lat
  // cycles later. Keeps answering across a DUT reset, which produces the
  // late rvalid the reset test needs.
  initial begin
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    forever begin
      @(negedge clk);
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b0;
      if (mem_pending) begin
        if (mem_wait == 0) begin
          instr_rvalid_i = 1'b1;
          instr_rdata_i  = mem_word(mem_addr);
          mem_pending    = 1'b0;
        end else begin
          mem_wait = mem_wait - 1;
        end
      end else if (instr_req_o) begin
        instr_gnt_i = 1'b1;
        mem_pending = 1'b1;
        mem_addr    = instr_addr_o;
        mem_wait    = rv_lat;
        gnt_log.push_back(instr_addr_o);
      end
    end
  end

  // Monitor: a pop happens at the next rising edge when valid & ready and
  // no branch/reset overrides it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && !branch_i && fetch_valid_o && fetch_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected actual=(%h,%h) required=none", fetch_addr_o, fetch_rdata_o);
        end else begin
          e = exp_q.pop_front();
          if (fetch_addr_o !== e.addr || fetch_rdata_o !== e.data) begin
            errors++;
            $display("FAIL pop_word actual=(%h,%h) required=(%h,%h)",
                     fetch_addr_o, fetch_rdata_o, e.addr, e.data);
          end else begin
            $display("pop addr=%h data=%h ok", fetch_addr_o, fetch_rdata_o);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, actual, expected);
    end else begin
      $display("check %s = %h ok", name, actual);
    end
  endtask

  task automatic expect_word(input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d words left required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},    32'(instr_req_o),   32'h0);
    check({tag, "_addr"},   32'(instr_addr_o),  32'h0);
    check({tag, "_valid"},  32'(fetch_valid_o), 32'h0);
    check({tag, "_rdata"},  fetch_rdata_o,      32'h0);
    check({tag, "_faddr"},  32'(fetch_addr_o),  32'h0);
  endtask

  // Stop fetching, let the outstanding transfer finish, then redirect to
  // target with a one-cycle branch which also empties the FIFO.
  task automatic stop_and_flush(input logic [7:0] target);
    enable_i      = 1'b0;
    fetch_ready_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!instr_req_o && !mem_pending) break;
      step();
    end
    step();
    branch_i      = 1'b1;
    branch_addr_i = target;
    step();
    branch_i = 1'b0;
    check("flush_valid", 32'(fetch_valid_o), 32'h0);
  endtask

  initial begin
    int base;
    int base2;
    bit seen;

    rst = 1'b1; enable_i = 1'b0; fetch_ready_i = 1'b0;
    branch_i = 1'b0; branch_addr_i = '0;

    // Reset values and the boot stream
    step(); step(); step();
    check_reset_outputs("reset");
    rst = 1'b0; enable_i = 1'b1; fetch_ready_i = 1'b1;
    expect_word(8'h00, 32'h00D00113);
    expect_word(8'h04, 32'h00900093);
    expect_word(8'h08, 32'h401101B3);
    step();
    check("first_req",  32'(instr_req_o),  32'h1);
    check("first_addr", 32'(instr_addr_o), 32'h0);
    wait_drain("boot", 40);
    stop_and_flush(8'h00);

    // Consumer stalled from reset: exactly FIFO_DEPTH grants
    rst = 1'b1; step();
    rst = 1'b0; enable_i = 1'b1; fetch_ready_i = 1'b0;
    base = gnt_log.size();
    for (int i = 0; i < 20; i++) step();
    check("stall_gnts",  32'(gnt_log.size() - base), 32'd2);
    check("stall_req",   32'(instr_req_o),   32'h0);
    check("stall_valid", 32'(fetch_valid_o), 32'h1);
    check("stall_head",  32'(fetch_addr_o),  32'h00);
    expect_word(8'h00, 32'h00D00113);
    expect_word(8'h04, 32'h00900093);
    expect_word(8'h08, 32'h401101B3);
    fetch_ready_i = 1'b1;
    wait_drain("stall", 40);
    if (gnt_log.size() > base + 2) check("stall_resume_addr", 32'(gnt_log[base+2]), 32'h08);
    else check("stall_resume_gnts", 32'(gnt_log.size() - base), 32'd3);
    stop_and_flush(8'h00);

    // Branch while waiting for the 0x0C response
    rst = 1'b1; step();
    rst = 1'b0; rv_lat = 3; enable_i = 1'b1; fetch_ready_i = 1'b1;
    base = gnt_log.size();
    expect_word(8'h00, 32'h00D00113);
    expect_word(8'h04, 32'h00900093);
    expect_word(8'h08, 32'h401101B3);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (gnt_log.size() >= base + 4) begin seen = 1'b1; break; end
      step();
    end
    check("wait_0c_seen", 32'(seen), 32'h1);
    step();
    if (seen) check("wait_0c_addr", 32'(gnt_log[base+3]), 32'h0C);
    check("pre_branch_drained", 32'(exp_q.size()), 32'd0);
    branch_i = 1'b1; branch_addr_i = 8'h80;
    expect_word(8'h80, 32'hF81FF06F);
    expect_word(8'h84, 32'h1A1A1A1A);
    step();
    branch_i = 1'b0;
    check("branch_valid", 32'(fetch_valid_o), 32'h0);
    wait_drain("branch80", 80);
    if (gnt_log.size() > base + 4) check("branch80_req", 32'(gnt_log[base+4]), 32'h80);
    else check("branch80_gnts", 32'(gnt_log.size() - base), 32'd5);
    stop_and_flush(8'hFC);

    // Address wrap from 0xFC to 0x00
    rv_lat = 0;
    base = gnt_log.size();
    enable_i = 1'b1; fetch_ready_i = 1'b1;
    expect_word(8'hFC, 32'h111100FC);
    expect_word(8'h00, 32'h00D00113);
    wait_drain("wrap", 40);
    if (gnt_log.size() > base + 1) begin
      check("wrap_req0", 32'(gnt_log[base]),   32'hFC);
      check("wrap_req1", 32'(gnt_log[base+1]), 32'h00);
    end else begin
      check("wrap_gnts", 32'(gnt_log.size() - base), 32'd2);
    end
    stop_and_flush(8'h43);   // unaligned target lands on 0x40

    // Branch coinciding with a pop and an rvalid
    base = gnt_log.size();
    enable_i = 1'b1; fetch_ready_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (instr_rvalid_i && fetch_valid_o) begin seen = 1'b1; break; end
      step();
    end
    check("coincide_seen", 32'(seen), 32'h1);
    check("coincide_head", 32'(fetch_addr_o), 32'h40);
    branch_i = 1'b1; branch_addr_i = 8'hA0; fetch_ready_i = 1'b1;
    step();
    branch_i = 1'b0;
    check("coincide_valid", 32'(fetch_valid_o), 32'h0);
    check("coincide_req",   32'(instr_req_o),   32'h1);
    check("coincide_addr",  32'(instr_addr_o),  32'hA0);
    expect_word(8'hA0, 32'h111100A0);
    expect_word(8'hA4, 32'h111100A4);
    wait_drain("coincide", 40);
    if (gnt_log.size() > base + 2) check("coincide_gnt", 32'(gnt_log[base+2]), 32'hA0);
    else check("coincide_gnts", 32'(gnt_log.size() - base), 32'd3);
    stop_and_flush(8'h20);

    // Reset during WAIT_RV followed by a late rvalid
    rv_lat = 3;
    base = gnt_log.size();
    enable_i = 1'b1; fetch_ready_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (gnt_log.size() > base) begin seen = 1'b1; break; end
      step();
    end
    check("rst_gnt_seen", 32'(seen), 32'h1);
    if (seen) check("rst_gnt_addr", 32'(gnt_log[base]), 32'h20);
    step();
    enable_i = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("midrst");
    for (int i = 0; i < 10; i++) begin
      if (!mem_pending) break;
      step();
    end
    step(); step();
    check("late_rv_valid", 32'(fetch_valid_o), 32'h0);
    check("late_rv_req",   32'(instr_req_o),   32'h0);
    rv_lat = 0;
    base2 = gnt_log.size();
    enable_i = 1'b1;
    expect_word(8'h00, 32'h00D00113);
    wait_drain("after_rst", 40);
    if (gnt_log.size() > base2) check("after_rst_req", 32'(gnt_log[base2]), 32'h00);
    else check("after_rst_gnts", 32'(gnt_log.size() - base2), 32'd1);
    enable_i = 1'b0; fetch_ready_i = 1'b0;
    step(); step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
